// File: rtl/mips_pkg.sv
// Shared MIPS store-path definitions: store op encodings, exception codes
// and the packed write-buffer entry format.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_SW  = 2'd0,
        ST_SH  = 2'd1,
        ST_SB  = 2'd2,
        ST_RSV = 2'd3
    } st_op_e;

    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam int         BE_W     = 4;

    typedef struct packed {
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [BE_W-1:0] be;
    } st_entry_t;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational lane packer: replicates the store operand across the word and
// derives byte enables, plus misalignment / illegal-op flags.
module store_lane_pack
    import mips_pkg::*;
(
    input  logic [1:0]      op,
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     data,
    output logic [31:0]     wdata,
    output logic [BE_W-1:0] be,
    output logic            misalign,
    output logic            illegal
);

    always_comb begin
        wdata    = data;
        be       = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (st_op_e'(op))
            ST_SW: begin
                wdata    = data;
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            ST_SH: begin
                wdata    = {2{data[15:0]}};
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            ST_SB: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_packer.sv
// Store write buffer: packs MEM-stage stores into byte lanes, queues them in a
// small FIFO for the data memory, and rejects misaligned/illegal stores.
module store_packer
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [31:0]              in_addr,
    input  logic [31:0]              in_data,
    output logic                     exc_valid,
    output logic [4:0]               exc_code,
    output logic [31:0]              exc_addr,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [BE_W-1:0]          mem_be,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [31:0]     w_wdata;
    logic [BE_W-1:0] w_be;
    logic            w_misalign;
    logic            w_illegal;
    logic            w_accept;
    logic            w_reject;
    logic            w_enq;
    logic            w_pop;
    st_entry_t       w_entry;
    st_entry_t       w_head;

    st_entry_t       r_fifo [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_exc_valid;
    logic [4:0]      r_exc_code;
    logic [31:0]     r_exc_addr;

    store_lane_pack u_lane_pack (
        .op       (in_op),
        .addr_lo  (in_addr[1:0]),
        .data     (in_data),
        .wdata    (w_wdata),
        .be       (w_be),
        .misalign (w_misalign),
        .illegal  (w_illegal)
    );

    // Ready and empty depend on the occupancy only, never on the handshakes.
    assign in_ready = (r_count != CNT_FULL);
    assign empty    = (r_count == '0);
    assign count    = r_count;

    assign w_accept = in_valid && in_ready;
    assign w_reject = w_accept && (w_misalign || w_illegal);
    assign w_enq    = w_accept && !(w_misalign || w_illegal);
    assign w_pop    = mem_valid && mem_ready;

    assign w_entry.addr  = {in_addr[31:2], 2'b00};
    assign w_entry.wdata = w_wdata;
    assign w_entry.be    = w_be;

    // Storage carries no reset; the head is read asynchronously so a store
    // written at edge N is presented right after that edge.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo[r_wr_ptr] <= w_entry;
        end
    end

    assign w_head    = r_fifo[r_rd_ptr];
    assign mem_valid = !empty;
    assign mem_addr  = w_head.addr;
    assign mem_wdata = w_head.wdata;
    assign mem_be    = w_head.be;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_exc_valid <= 1'b0;
            r_exc_code  <= '0;
            r_exc_addr  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_exc_valid <= w_reject;
            if (w_reject) begin
                r_exc_code <= w_illegal ? EXC_RI : EXC_ADES;
                r_exc_addr <= in_addr;
            end
        end
    end

    assign exc_valid = r_exc_valid;
    assign exc_code  = r_exc_code;
    assign exc_addr  = r_exc_addr;

endmodule

// File: tb/tb_store_packer.sv
// Self-checking bench for store_packer: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_store_packer;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [1:0]  count;
    logic        empty;

    store_packer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .exc_valid (exc_valid),
        .exc_code  (exc_code),
        .exc_addr  (exc_addr),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .count     (count),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t        q[$];
    logic        m_exc_v;
    logic [4:0]  m_exc_code;
    logic [31:0] m_exc_addr;
    int          checks;
    int          errors;

    // Reference packing from the store rules: size in bytes, alignment by modulo,
    // lane replication by multiplication, enables as a run of size ones.
    function automatic void model_pack(input logic [1:0] op, input logic [31:0] addr,
                                       input logic [31:0] data, output logic bad,
                                       output logic [4:0] code, output ent_t e);
        int size;
        int offs;
        size = (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : 1;
        offs = int'(addr % 4);
        bad  = 1'b0;
        code = 5'd0;
        if (op == 2'd3) begin
            bad  = 1'b1;
            code = 5'd10;
        end else if ((addr % size) != 0) begin
            bad  = 1'b1;
            code = 5'd5;
        end
        e.addr = addr - (addr % 4);
        if (size == 4)      e.wdata = data;
        else if (size == 2) e.wdata = (data % 32'h10000) * 32'h00010001;
        else                e.wdata = (data % 32'h100) * 32'h01010101;
        e.be = 4'(((1 << size) - 1) << offs);
    endfunction

    task automatic model_reset();
        q.delete();
        m_exc_v    = 1'b0;
        m_exc_code = 5'd0;
        m_exc_addr = 32'd0;
    endtask

    // Advance one clock edge and update the model with what that edge does.
    task automatic tick();
        logic acc;
        logic pop;
        logic bad;
        logic [4:0] code;
        ent_t e;
        acc = in_valid && (q.size() < DEPTH);
        pop = (q.size() > 0) && mem_ready;
        model_pack(in_op, in_addr, in_data, bad, code, e);
        @(posedge clk);
        #1;
        if (pop) begin
            $display("pop  addr=%h wdata=%h be=%b", q[0].addr, q[0].wdata, q[0].be);
            void'(q.pop_front());
        end
        m_exc_v = acc && bad;
        if (acc && bad) begin
            m_exc_code = code;
            m_exc_addr = in_addr;
            $display("rej  op=%0d addr=%h code=%0d", in_op, in_addr, code);
        end
        if (acc && !bad) begin
            q.push_back(e);
            $display("push op=%0d addr=%h data=%h", in_op, in_addr, in_data);
        end
    endtask

    task automatic set_req(input logic v, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] d);
        in_valid = v;
        in_op    = op;
        in_addr  = a;
        in_data  = d;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        set_req(1'b0, 2'd0, 32'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({count, empty, in_ready, mem_valid, exc_valid} !== {2'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got cnt=%0d e=%b r=%b mv=%b ev=%b exp cnt=0 e=1 r=1 mv=0 ev=0",
                     count, empty, in_ready, mem_valid, exc_valid);
        end
        checks++;
        if ({exc_code, exc_addr} !== 37'd0) begin
            errors++;
            $display("FAIL reset_exc got code=%0d addr=%h exp 0/0", exc_code, exc_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_sw_basic();
        mem_ready = 1'b1;
        set_req(1'b1, 2'd0, 32'h0000_1000, 32'hDEAD_BEEF);
        tick();
        set_req(1'b0, 2'd0, 32'd0, 32'd0);
        checks++;
        if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h1000, 32'hDEADBEEF, 4'b1111}) begin
            errors++;
            $display("FAIL sw_basic got v=%b a=%h d=%h be=%b exp v=1 a=00001000 d=deadbeef be=1111",
                     mem_valid, mem_addr, mem_wdata, mem_be);
        end
        tick();
        checks++;
        if ({empty, mem_valid} !== 2'b10) begin
            errors++;
            $display("FAIL sw_drain got empty=%b mv=%b exp empty=1 mv=0", empty, mem_valid);
        end
    endtask

    task automatic test_lanes();
        mem_ready = 1'b0;
        set_req(1'b1, 2'd2, 32'h0000_2003, 32'h1234_56AB);
        tick();
        checks++;
        if ({mem_addr, mem_wdata, mem_be} !== {32'h2000, 32'hABABABAB, 4'b1000}) begin
            errors++;
            $display("FAIL sb_lane got a=%h d=%h be=%b exp a=00002000 d=abababab be=1000",
                     mem_addr, mem_wdata, mem_be);
        end
        mem_ready = 1'b1;
        set_req(1'b1, 2'd1, 32'h0000_2002, 32'hFFFF_7777);
        tick();
        set_req(1'b0, 2'd0, 32'd0, 32'd0);
        checks++;
        if ({count, mem_addr, mem_wdata, mem_be} !== {2'd1, 32'h2000, 32'h77777777, 4'b1100}) begin
            errors++;
            $display("FAIL sh_lane got c=%0d a=%h d=%h be=%b exp c=1 a=00002000 d=77777777 be=1100",
                     count, mem_addr, mem_wdata, mem_be);
        end
        tick();
    endtask

    task automatic test_full();
        logic [31:0] items [3];
        for (int i = 0; i < 3; i++) items[i] = $urandom;
        mem_ready = 1'b0;
        set_req(1'b1, 2'd0, 32'h0000_3000, items[0]);
        tick();
        set_req(1'b1, 2'd0, 32'h0000_3004, items[1]);
        tick();
        set_req(1'b1, 2'd0, 32'h0000_3008, items[2]);
        tick();
        tick();
        checks++;
        if ({count, in_ready, mem_wdata} !== {2'd2, 1'b0, items[0]}) begin
            errors++;
            $display("FAIL full_hold got c=%0d r=%b d=%h exp c=2 r=0 d=%h",
                     count, in_ready, mem_wdata, items[0]);
        end
        mem_ready = 1'b1;
        tick();
        checks++;
        if ({count, in_ready, mem_addr, mem_wdata} !== {2'd1, 1'b1, 32'h3004, items[1]}) begin
            errors++;
            $display("FAIL full_pop1 got c=%0d r=%b a=%h d=%h exp c=1 r=1 a=00003004 d=%h",
                     count, in_ready, mem_addr, mem_wdata, items[1]);
        end
        tick();
        set_req(1'b0, 2'd0, 32'd0, 32'd0);
        checks++;
        if ({count, mem_addr, mem_wdata} !== {2'd1, 32'h3008, items[2]}) begin
            errors++;
            $display("FAIL full_third got c=%0d a=%h d=%h exp c=1 a=00003008 d=%h",
                     count, mem_addr, mem_wdata, items[2]);
        end
        tick();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL full_drain got empty=%b exp 1", empty);
        end
    endtask

    task automatic test_exceptions();
        logic [31:0] ra;
        mem_ready = 1'b1;
        set_req(1'b1, 2'd0, 32'h0000_1002, 32'h5555_AAAA);
        tick();
        checks++;
        if ({exc_valid, exc_code, exc_addr, mem_valid} !== {1'b1, 5'd5, 32'h1002, 1'b0}) begin
            errors++;
            $display("FAIL exc_ades got v=%b code=%0d a=%h mv=%b exp v=1 code=5 a=00001002 mv=0",
                     exc_valid, exc_code, exc_addr, mem_valid);
        end
        ra = $urandom & 32'hFFFF_FFFC;
        set_req(1'b1, 2'd3, ra, $urandom);
        tick();
        checks++;
        if ({exc_valid, exc_code, exc_addr, mem_valid} !== {1'b1, 5'd10, ra, 1'b0}) begin
            errors++;
            $display("FAIL exc_ri got v=%b code=%0d a=%h mv=%b exp v=1 code=10 a=%h mv=0",
                     exc_valid, exc_code, exc_addr, mem_valid, ra);
        end
        set_req(1'b1, 2'd1, 32'h0000_4001, $urandom);
        tick();
        checks++;
        if ({exc_valid, exc_code, exc_addr} !== {1'b1, 5'd5, 32'h4001}) begin
            errors++;
            $display("FAIL exc_sh got v=%b code=%0d a=%h exp v=1 code=5 a=00004001",
                     exc_valid, exc_code, exc_addr);
        end
        set_req(1'b0, 2'd0, 32'd0, 32'd0);
        tick();
        checks++;
        if ({exc_valid, empty} !== 2'b01) begin
            errors++;
            $display("FAIL exc_pulse got v=%b empty=%b exp v=0 empty=1", exc_valid, empty);
        end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b0;
        set_req(1'b1, 2'd0, 32'h0000_5000, $urandom);
        tick();
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, 2'd0, 32'h0000_5000 + 32'(4 * (i + 1)), $urandom);
            tick();
            checks++;
            if (count !== 2'd1 || q.size() != 1) begin
                errors++;
                $display("FAIL b2b_count[%0d] got %0d exp 1", i, count);
            end else begin
                checks++;
                if ({mem_addr, mem_wdata, mem_be} !== {q[0].addr, q[0].wdata, q[0].be}) begin
                    errors++;
                    $display("FAIL b2b_order[%0d] got a=%h d=%h exp a=%h d=%h",
                             i, mem_addr, mem_wdata, q[0].addr, q[0].wdata);
                end
            end
        end
        set_req(1'b0, 2'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            set_req(1'($urandom_range(0, 3) != 0), op, $urandom, $urandom);
            if ($urandom_range(0, 1) == 1) in_addr[1:0] = 2'b00;
            mem_ready = ($urandom_range(0, 2) != 0);
            tick();
            checks++;
            if ({count, empty, in_ready, mem_valid, exc_valid} !==
                {2'(q.size()), q.size() == 0, q.size() < DEPTH, q.size() != 0, m_exc_v}) begin
                errors++;
                $display("FAIL rnd_state[%0d] got c=%0d e=%b r=%b mv=%b ev=%b exp c=%0d ev=%b",
                         i, count, empty, in_ready, mem_valid, exc_valid, q.size(), m_exc_v);
            end
            if (q.size() != 0) begin
                checks++;
                if ({mem_addr, mem_wdata, mem_be} !== {q[0].addr, q[0].wdata, q[0].be}) begin
                    errors++;
                    $display("FAIL rnd_head[%0d] got a=%h d=%h be=%b exp a=%h d=%h be=%b",
                             i, mem_addr, mem_wdata, mem_be, q[0].addr, q[0].wdata, q[0].be);
                end
            end
            if (m_exc_v) begin
                checks++;
                if ({exc_code, exc_addr} !== {m_exc_code, m_exc_addr}) begin
                    errors++;
                    $display("FAIL rnd_exc[%0d] got code=%0d a=%h exp code=%0d a=%h",
                             i, exc_code, exc_addr, m_exc_code, m_exc_addr);
                end
            end
        end
        set_req(1'b0, 2'd0, 32'd0, 32'd0);
        mem_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b1;
        set_req(1'b1, 2'd0, 32'h0000_6002, $urandom);
        tick();
        set_req(1'b0, 2'd0, 32'd0, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({exc_valid, exc_code, exc_addr} !== 38'd0) begin
            errors++;
            $display("FAIL rst_exc got v=%b code=%0d a=%h exp all 0", exc_valid, exc_code, exc_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        mem_ready = 1'b0;
        set_req(1'b1, 2'd0, 32'h0000_7000, $urandom);
        tick();
        set_req(1'b1, 2'd0, 32'h0000_7004, $urandom);
        tick();
        set_req(1'b0, 2'd0, 32'd0, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({count, empty, mem_valid, in_ready} !== {2'd0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_full got c=%0d e=%b mv=%b r=%b exp c=0 e=1 mv=0 r=1",
                     count, empty, mem_valid, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        mem_ready = 1'b1;
        tick();
        checks++;
        if ({empty, mem_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rst_stale got empty=%b mv=%b exp empty=1 mv=0", empty, mem_valid);
        end
        mem_ready = 1'b0;
        set_req(1'b1, 2'd2, 32'h0000_8001, 32'h0000_00C3);
        tick();
        set_req(1'b0, 2'd0, 32'd0, 32'd0);
        checks++;
        if ({count, mem_addr, mem_wdata, mem_be} !== {2'd1, 32'h8000, 32'hC3C3C3C3, 4'b0010}) begin
            errors++;
            $display("FAIL rst_fresh got c=%0d a=%h d=%h be=%b exp c=1 a=00008000 d=c3c3c3c3 be=0010",
                     count, mem_addr, mem_wdata, mem_be);
        end
        mem_ready = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sw_basic();
        test_lanes();
        test_full();
        test_exceptions();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
